ones_pattern_gen: RTL and testbench
===================================

Name: ones_pattern_gen

Overview:
- Sequential generator for a requested bit weight k (0..8): emits, in ascending numeric order, every 8-bit word with exactly k bits set.
- Serves as the stimulus/reference source paired with the 8-bit ones counter: it produces words of a known weight, and the counter checks them.
- Output uses a valid/ready stream with a last flag.
- One word is tested per clock; a candidate scan is qualified by an internal population count.

Parameters:
- DW, 8, data word width; only 8 is supported.
- CW, 4, width of k and of the internal popcount; must be >= clog2(DW+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- k  in  CW  requested weight; sampled with start.
- dout  out  DW  current matching word.
- dout_valid  out  1  dout holds a matching word.
- dout_ready  in  1  consumer accepts dout when valid and ready are both high.
- dout_last  out  1  high together with the final word of the sequence.
- busy  out  1  high in SCAN or HOLD.
- done  out  1  one-cycle pulse after the last word is accepted.
- err  out  1  one-cycle pulse when start arrives with k > DW.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, cand=0, k_reg=0; dout=0, dout_valid=0, dout_last=0, busy=0, done=0, err=0.
- State IDLE:
  - start & k<=8: k_reg<=k, cand<=0, go to SCAN.
  - start & k>8: err=1 for one cycle, stay in IDLE, no output.
  - start while busy is ignored.
- State SCAN, one candidate per cycle:
  - cand is 9 bits wide. If popcount(cand[7:0])==k_reg, then dout<=cand[7:0], dout_valid<=1, dout_last<=(cand[7:0]==LASTW), go to HOLD.
  - Otherwise cand<=cand+1.
  - LASTW = ((8'hFF << (8-k_reg)) & 8'hFF), so k=0 gives 0x00 and k=8 gives 0xFF.
- State HOLD:
  - dout, dout_valid and dout_last stay stable until dout_ready.
  - On the accept cycle: if dout_last, then dout_valid<=0, done<=1 next cycle, go to IDLE. Else dout_valid<=0, cand<=cand+1, go to SCAN.
- Latency:
  - First word appears at least 2 cycles after start (start, then SCAN hit, then valid).
  - Gap between words = accept cycle + (distance to next match) cycles.
  - No back-to-back output; throughput ≤1 word per 2 cycles.
- Valid never drops without an accept. dout_ready while not valid has no effect.
- The sequence length is C(8,k). The last word is flagged by value, not by count.
- cand never exceeds 255 in a legal run, because LASTW always terminates the scan. Bit 8 of cand is a guard: if it ever sets, go to IDLE with done=0 and err=1.
- Reset mid-operation: immediate return to reset values. The sequence is abandoned; no done pulse.
- The popcount is purely combinational on cand[7:0]; its result is CW bits wide, zero-extended before comparison with k_reg.

Decomposition:
- Shared package holds:
  - DW=8, CW=4, KMAX=8.
  - State encoding: IDLE=2'd0, SCAN=2'd1, HOLD=2'd2.
  - LASTW computation as a function.
- One natural sub-module: pop_count8 (8-bit in, 4-bit count out, combinational adder tree). It is instantiated once to qualify candidates.

Test Plan:
- k=0, dout_ready held 1 → exactly one word 0x00 with dout_last=1; done pulses once; busy then drops.
- k=1, ready=1 → words 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80; last only on 0x80; 8 accepts total.
- k=4, ready=1 → 70 words, first 0x0F, second 0x17, final 0xF0 with last; every word checked against an independent popcount==4; strictly ascending.
- k=8 with dout_ready toggling pseudo-randomly → single word 0xFF; dout/dout_last stable while valid&!ready; done one cycle after accept.
- start with k=9 → err pulses 1 cycle, dout_valid never rises, busy stays 0; a start during busy with a different k is ignored.
- k=2, assert rst after the 3rd accept (0x09 emitted) → all outputs 0 asynchronously; a new start k=7 yields 0x7F,0xBF,0xDF,0xEF,0xF7,0xFB,0xFD,0xFE with last on 0xFE.

Source files
------------

// File: rtl/ones_pattern_gen_pkg.sv
// Shared constants, state encoding and helpers
// for the fixed-weight word generator.
package ones_pattern_gen_pkg;

   localparam int DW = 8;
   localparam int CW = 4;
   localparam logic [CW-1:0] KMAX = 4'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Largest DW-bit word of weight k: k ones packed at the top.
   function automatic logic [DW-1:0] last_word(input logic [CW-1:0] kw);
      logic [2*DW-1:0] w;
      w = 16'h00FF << (4'(DW) - kw);
      return w[DW-1:0];
   endfunction

endpackage

// File: rtl/ones_pattern_gen_if.sv
// Output word stream: valid/ready handshake
// with an end-of-sequence flag.
interface ones_pattern_gen_if;
   import ones_pattern_gen_pkg::*;

   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic          dout_last;

   modport master (
      output dout,
      output dout_valid,
      output dout_last,
      input  dout_ready
   );

   modport slave (
      input  dout,
      input  dout_valid,
      input  dout_last,
      output dout_ready
   );

endinterface

// File: rtl/ones_pattern_gen_pop_count8.sv
// Combinational 8-bit population count
// built as a three-level adder tree.
module pop_count8
   import ones_pattern_gen_pkg::*;
(
   input  logic [7:0]    a,
   output logic [CW-1:0] cnt
);

   logic [1:0] s0, s1, s2, s3;
   logic [2:0] t0, t1;

   // Pairs, then quads, then the full byte.
   always_comb begin
      s0  = {1'b0, a[0]} + {1'b0, a[1]};
      s1  = {1'b0, a[2]} + {1'b0, a[3]};
      s2  = {1'b0, a[4]} + {1'b0, a[5]};
      s3  = {1'b0, a[6]} + {1'b0, a[7]};
      t0  = {1'b0, s0} + {1'b0, s1};
      t1  = {1'b0, s2} + {1'b0, s3};
      cnt = {1'b0, t0} + {1'b0, t1};
   end

endmodule

// File: rtl/ones_pattern_gen.sv
// Emits every 8-bit word of weight k in
// ascending order on a valid/ready stream.
module ones_pattern_gen
   import ones_pattern_gen_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [CW-1:0]       k,
   ones_pattern_gen_if.master  dout_if,
   output logic                busy,
   output logic                done,
   output logic                err
);

   state_t        state, state_n;
   logic [DW:0]   cand;
   logic [CW-1:0] k_reg;
   logic [CW-1:0] pop;
   logic          hit;
   logic [DW-1:0] dout_q;
   logic          valid_q;
   logic          last_q;

   pop_count8 u_pop (
      .a   (cand[DW-1:0]),
      .cnt (pop)
   );

   assign hit = (pop == k_reg);

   assign dout_if.dout       = dout_q;
   assign dout_if.dout_valid = valid_q;
   assign dout_if.dout_last  = last_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next state: scan until a hit, hold until accepted.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (start && k <= KMAX) state_n = SCAN;
         SCAN: begin
            if (cand[DW])  state_n = IDLE;
            else if (hit)  state_n = HOLD;
         end
         HOLD: begin
            if (dout_if.dout_ready)
               state_n = last_q ? IDLE : SCAN;
         end
         default: state_n = IDLE;
      endcase
   end

   // Busy whenever a sequence is in flight.
   always_comb begin
      busy = (state != IDLE);
   end

   // Candidate counter, output word register and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand    <= '0;
         k_reg   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (k <= KMAX) begin
                     k_reg <= k;
                     cand  <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (cand[DW]) begin
                  err <= 1'b1;
               end else if (hit) begin
                  dout_q  <= cand[DW-1:0];
                  valid_q <= 1'b1;
                  last_q  <= (cand[DW-1:0] == last_word(k_reg));
               end else begin
                  cand <= cand + 9'd1;
               end
            end
            HOLD: begin
               if (dout_if.dout_ready) begin
                  valid_q <= 1'b0;
                  if (last_q) done <= 1'b1;
                  else        cand <= cand + 9'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen with
// hand-computed word lists.
module tb_ones_pattern_gen;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] k;
   logic       busy;
   logic       done;
   logic       err;

   int errors = 0;
   int checks = 0;

   logic [7:0] got[$];
   logic       lastq[$];

   ones_pattern_gen_if s_if ();

   ones_pattern_gen dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .k       (k),
      .dout_if (s_if),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_pop(input logic [7:0] v);
      int c;
      c = 0;
      for (int i = 0; i < 8; i++) c += int'(v[i]);
      return c;
   endfunction

   // Start a run and collect accepted words until the last one.
   task automatic run_seq(input logic [3:0] kk, input bit rnd,
                          input bit poke, input int budget);
      logic [7:0] pd;
      logic       pl;
      bit         hold;
      bit         acc_last;
      bit         fin;
      int         cyc;
      int         early_done;
      got.delete();
      lastq.delete();
      start = 1'b1;
      k     = kk;
      @(negedge clk);
      start = 1'b0;
      hold = 0; fin = 0; cyc = 0; early_done = 0;
      pd = '0; pl = 1'b0;
      while (!fin && cyc < budget) begin
         start = 1'b0;
         if (poke && cyc == 1) begin
            start = 1'b1;
            k     = 4'd3;
         end
         if (done) early_done++;
         if (s_if.dout_valid && hold) begin
            chk("stable_dout", s_if.dout, pd);
            chk("stable_last", s_if.dout_last, pl);
         end
         s_if.dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (s_if.dout_valid && s_if.dout_ready) begin
            got.push_back(s_if.dout);
            lastq.push_back(s_if.dout_last);
         end
         hold     = s_if.dout_valid && !s_if.dout_ready;
         pd       = s_if.dout;
         pl       = s_if.dout_last;
         acc_last = s_if.dout_valid && s_if.dout_ready && s_if.dout_last;
         @(negedge clk);
         cyc++;
         if (acc_last) begin
            chk("done_after_last", done, 1);
            chk("busy_after_last", busy, 0);
            fin = 1;
         end
      end
      start = 1'b0;
      if (!fin) chk("seq_timeout", 0, 1);
      chk("no_early_done", early_done, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      logic [7:0] exp1 [8];
      logic [7:0] exp7 [8];
      int n;
      int cyc;
      exp1 = '{8'h01, 8'h02, 8'h04, 8'h08,
               8'h10, 8'h20, 8'h40, 8'h80};
      exp7 = '{8'h7F, 8'hBF, 8'hDF, 8'hEF,
               8'hF7, 8'hFB, 8'hFD, 8'hFE};

      rst = 1'b1;
      start = 1'b0;
      k = '0;
      s_if.dout_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_dout", s_if.dout, 0);
      chk("rst_valid", s_if.dout_valid, 0);
      chk("rst_last", s_if.dout_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      @(negedge clk);

      // k=0: single word 0x00 flagged last.
      run_seq(4'd0, 0, 0, 100);
      chk("k0_count", got.size(), 1);
      if (got.size() == 1) begin
         chk("k0_word", got[0], 8'h00);
         chk("k0_last", lastq[0], 1);
      end

      // k=1 with a start poked mid-run that must be ignored.
      run_seq(4'd1, 0, 1, 1000);
      chk("k1_count", got.size(), 8);
      for (int i = 0; i < got.size() && i < 8; i++) begin
         chk("k1_word", got[i], exp1[i]);
         chk("k1_last", lastq[i], (i == 7) ? 1 : 0);
      end

      // k=4: 70 ascending words of weight 4.
      run_seq(4'd4, 0, 0, 2000);
      chk("k4_count", got.size(), 70);
      if (got.size() == 70) begin
         chk("k4_first", got[0], 8'h0F);
         chk("k4_second", got[1], 8'h17);
         chk("k4_final", got[69], 8'hF0);
      end
      for (int i = 0; i < got.size(); i++) begin
         chk("k4_pop", ref_pop(got[i]), 4);
         chk("k4_last", lastq[i], (i == 69) ? 1 : 0);
         if (i > 0) chk("k4_ascend", (got[i] > got[i-1]) ? 1 : 0, 1);
      end

      // k=8 with random ready: single word 0xFF.
      run_seq(4'd8, 1, 0, 2000);
      chk("k8_count", got.size(), 1);
      if (got.size() == 1) begin
         chk("k8_word", got[0], 8'hFF);
         chk("k8_last", lastq[0], 1);
      end

      // k=9 is rejected with an err pulse.
      s_if.dout_ready = 1'b1;
      start = 1'b1;
      k = 4'd9;
      @(negedge clk);
      start = 1'b0;
      chk("k9_err", err, 1);
      chk("k9_busy", busy, 0);
      chk("k9_valid", s_if.dout_valid, 0);
      @(negedge clk);
      chk("k9_err_pulse", err, 0);
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (s_if.dout_valid || busy) n++;
      end
      chk("k9_quiet", n, 0);

      // k=2, reset while the 4th word (0x09) is presented.
      start = 1'b1;
      k = 4'd2;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      cyc = 0;
      while (n < 3 && cyc < 200) begin
         if (s_if.dout_valid && s_if.dout_ready) n++;
         @(negedge clk);
         cyc++;
      end
      s_if.dout_ready = 1'b0;
      while (!s_if.dout_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("k2_valid", s_if.dout_valid, 1);
      chk("k2_word4", s_if.dout, 8'h09);
      #2 rst = 1'b1;
      #1;
      chk("arst_dout", s_if.dout, 0);
      chk("arst_valid", s_if.dout_valid, 0);
      chk("arst_last", s_if.dout_last, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_err", err, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_no_done", done, 0);

      // k=7 after reset.
      run_seq(4'd7, 0, 0, 1000);
      chk("k7_count", got.size(), 8);
      for (int i = 0; i < got.size() && i < 8; i++) begin
         chk("k7_word", got[i], exp7[i]);
         chk("k7_last", lastq[i], (i == 7) ? 1 : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
